// File: rtl/adc_decimator_if.sv
// -----------------------------------------------------------------------------
// adc_decimator_if
// Signal bundle between the ADC front end / trigger logic and the decimator.
//
// Signals (directions seen from the decimator, i.e. the slave modport):
//   adc_data_i      in  10  registered ADC sample, one per clk
//   adc_or_i        in   1  ADC out-of-range flag, aligned with adc_data_i
//   capture_go_i    in   1  capture enable, held high for the whole capture
//   decimate_i      in  16  D, group length L = D+1 samples
//   avg_shift_i     in   3  right shift applied to the group sum (averaging build)
//   max_samples_i   in  32  output-sample limit, 0 = unlimited
//   data_o          out 10  decimated sample
//   data_valid_o    out  1  one-cycle write strobe for data_o
//   or_o            out  1  OR of adc_or_i across the emitted group
//   capture_done_o  out  1  capture stopped on the sample limit
//   sample_count_o  out 32  output samples emitted in current/last capture
//
// Modports: master = ADC/trigger side, slave = decimator.
// -----------------------------------------------------------------------------
interface adc_decimator_if;
   logic [9:0]  adc_data_i;
   logic        adc_or_i;
   logic        capture_go_i;
   logic [15:0] decimate_i;
   logic [2:0]  avg_shift_i;
   logic [31:0] max_samples_i;
   logic [9:0]  data_o;
   logic        data_valid_o;
   logic        or_o;
   logic        capture_done_o;
   logic [31:0] sample_count_o;

   modport master (
      output adc_data_i, adc_or_i, capture_go_i, decimate_i, avg_shift_i, max_samples_i,
      input  data_o, data_valid_o, or_o, capture_done_o, sample_count_o
   );

   modport slave (
      input  adc_data_i, adc_or_i, capture_go_i, decimate_i, avg_shift_i, max_samples_i,
      output data_o, data_valid_o, or_o, capture_done_o, sample_count_o
   );
endinterface

// File: rtl/adc_decimator.sv
// -----------------------------------------------------------------------------
// adc_decimator
// Decimates the ADC sample stream by groups of L = D+1 samples for the
// capture FIFO. A capture starts when capture_go_i rises (configuration is
// latched on that edge, that edge's sample is skipped) and ends when
// capture_go_i drops or when the emitted-sample count reaches max_samples_i.
//
// Group processing, selected by macro DECIMATOR_AVERAGE_EN:
//   defined   : 26-bit sum of all L samples, shifted right by avg_shift,
//               saturated to 10'h3FF
//   undefined : the first sample of each group is emitted
//
// Ports:
//   clk    in  ADC sample clock, rising edge
//   reset  in  asynchronous, active-high reset
//   bus    adc_decimator_if.slave (samples, config, decimated output, status)
// -----------------------------------------------------------------------------
module adc_decimator (
   input  logic           clk,
   input  logic           reset,
   adc_decimator_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] dec_q, dec_d;
   logic [31:0] max_q, max_d;
   logic [15:0] grp_cnt_q, grp_cnt_d;
   logic        or_acc_q, or_acc_d;
   logic [31:0] count_q, count_d;
   logic [9:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        or_q, or_d;

   logic        grp_start;
   logic        grp_end;
   logic        or_now;
   logic [31:0] count_inc;
   logic [9:0]  group_val;

`ifdef DECIMATOR_AVERAGE_EN
   logic [2:0]  shift_q, shift_d;
   logic [25:0] acc_q, acc_d;
   logic [25:0] sum_now;
   logic [25:0] sum_shifted;
`else
   logic [9:0]  first_q, first_d;
   logic        unused_shift;
`endif

   // Group bookkeeping shared by both builds. The sample on the current edge
   // opens a new group when the counter is 0, so stale sticky state is
   // masked off rather than needing a separate clear cycle.
   always_comb begin
      grp_start = (grp_cnt_q == 16'd0);
      grp_end   = (grp_cnt_q == dec_q);
      or_now    = (grp_start ? 1'b0 : or_acc_q) | bus.adc_or_i;
      count_inc = count_q + 32'd1;
   end

`ifdef DECIMATOR_AVERAGE_EN
   always_comb begin
      sum_now     = (grp_start ? 26'd0 : acc_q) + {16'd0, bus.adc_data_i};
      sum_shifted = sum_now >> shift_q;
      group_val   = (|sum_shifted[25:10]) ? 10'h3FF : sum_shifted[9:0];
   end
`else
   always_comb begin
      group_val = grp_start ? bus.adc_data_i : first_q;
   end

   // Shift amount only matters to the averaging build.
   assign unused_shift = ^bus.avg_shift_i;
`endif

   // Next-state and datapath.
   always_comb begin
      // NOTE: every *_d gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d   = state_q;
      dec_d     = dec_q;
      max_d     = max_q;
      grp_cnt_d = grp_cnt_q;
      or_acc_d  = or_acc_q;
      count_d   = count_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      or_d      = or_q;
`ifdef DECIMATOR_AVERAGE_EN
      shift_d   = shift_q;
      acc_d     = acc_q;
`else
      first_d   = first_q;
`endif

      case (state_q)
         IDLE: begin
            if (bus.capture_go_i) begin
               // Latch the configuration; this edge's sample is not consumed.
               state_d   = RUN;
               dec_d     = bus.decimate_i;
               max_d     = bus.max_samples_i;
               grp_cnt_d = 16'd0;
               or_acc_d  = 1'b0;
               count_d   = 32'd0;
`ifdef DECIMATOR_AVERAGE_EN
               shift_d   = bus.avg_shift_i;
               acc_d     = 26'd0;
`endif
            end
         end

         RUN: begin
            // One sample consumed every edge, including the edge on which
            // capture_go_i is seen low, so a group completing there is emitted.
            or_acc_d = or_now;
`ifdef DECIMATOR_AVERAGE_EN
            acc_d    = sum_now;
`else
            first_d  = group_val;
`endif
            if (grp_end) begin
               grp_cnt_d = 16'd0;
               valid_d   = 1'b1;
               data_d    = group_val;
               or_d      = or_now;
               count_d   = count_inc;
            end else begin
               grp_cnt_d = grp_cnt_q + 16'd1;
            end

            // Reaching the limit wins over a simultaneous go drop; DONE then
            // falls back to IDLE on the next edge anyway.
            if (grp_end && (max_q != 32'd0) && (count_inc == max_q)) begin
               state_d = DONE;
            end else if (!bus.capture_go_i) begin
               state_d = IDLE;
            end
         end

         DONE: begin
            if (!bus.capture_go_i) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         dec_q     <= 16'd0;
         max_q     <= 32'd0;
         grp_cnt_q <= 16'd0;
         or_acc_q  <= 1'b0;
         count_q   <= 32'd0;
         data_q    <= 10'd0;
         valid_q   <= 1'b0;
         or_q      <= 1'b0;
`ifdef DECIMATOR_AVERAGE_EN
         shift_q   <= 3'd0;
         acc_q     <= 26'd0;
`else
         first_q   <= 10'd0;
`endif
      end else begin
         state_q   <= state_d;
         dec_q     <= dec_d;
         max_q     <= max_d;
         grp_cnt_q <= grp_cnt_d;
         or_acc_q  <= or_acc_d;
         count_q   <= count_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         or_q      <= or_d;
`ifdef DECIMATOR_AVERAGE_EN
         shift_q   <= shift_d;
         acc_q     <= acc_d;
`else
         first_q   <= first_d;
`endif
      end
   end

   assign bus.data_o         = data_q;
   assign bus.data_valid_o   = valid_q;
   assign bus.or_o           = or_q;
   assign bus.capture_done_o = (state_q == DONE);
   assign bus.sample_count_o = count_q;

endmodule

// File: tb/tb_adc_decimator.sv
// -----------------------------------------------------------------------------
// tb_adc_decimator
// Self-checking bench for adc_decimator. A table of capture scenarios is run
// through one driver task that also models the expected group results and
// pushes them to a queue; a negedge monitor pops and compares on every
// data_valid_o. Reset behaviour and a mid-group reset are hand sequences.
// Expected values follow the build selected by DECIMATOR_AVERAGE_EN.
// -----------------------------------------------------------------------------
module tb_adc_decimator;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   adc_decimator_if bus ();

   adc_decimator dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [9:0]  data;
      logic        or_f;
      logic [31:0] count;
   } exp_t;

   typedef struct {
      string       name;
      int          d;
      int          shift;
      int          max;
      int          base;
      int          step;
      int          drop;       // sample index driven with capture_go_i=0, -1 = none
      int unsigned or_mask;    // bit k = adc_or_i on consumed sample k
      int          nsamp;
      int          exp_emits;
      bit          exp_done;
   } vec_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks     = 0;
   int   failures   = 0;
   int   seen_emits = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard side: every strobe must match the oldest expected group.
   always @(negedge clk) begin
      if (reset === 1'b0 && bus.data_valid_o === 1'b1) begin
         seen_emits++;
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("emit_data",  {22'd0, bus.data_o}, {22'd0, mon_e.data});
            check("emit_or",    {31'd0, bus.or_o},   {31'd0, mon_e.or_f});
            check("emit_count", bus.sample_count_o,  mon_e.count);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one capture, modelling the expected output of each completed group.
   task automatic run_capture(input vec_t v);
      logic [15:0] cnt;
      logic [25:0] acc;
      logic [25:0] sh;
      logic [9:0]  first;
      logic [9:0]  samp;
      logic [9:0]  last_data;
      logic        orf;
      logic [31:0] cnt_out;
      exp_t        e;
      bit          done;

      seen_emits = 0;
      cnt = 16'd0; acc = 26'd0; first = 10'd0; orf = 1'b0;
      cnt_out = 32'd0; last_data = 10'd0; done = 1'b0;

      bus.decimate_i    = 16'(v.d);
      bus.avg_shift_i   = 3'(v.shift);
      bus.max_samples_i = 32'(v.max);
      bus.capture_go_i  = 1'b1;
      bus.adc_data_i    = 10'h155;   // start-edge sample, must be skipped
      bus.adc_or_i      = 1'b1;
      tick();

      // Configuration changes during the capture must have no effect.
      bus.decimate_i    = 16'(v.d + 1);
      bus.avg_shift_i   = 3'(v.shift + 3);
      bus.max_samples_i = 32'd1;

      for (int k = 0; k < v.nsamp && !done; k++) begin
         samp             = 10'(v.base + v.step * k);
         bus.adc_data_i   = samp;
         bus.adc_or_i     = v.or_mask[k];
         bus.capture_go_i = (k != v.drop);
         if (cnt == 16'd0) begin
            acc   = {16'd0, samp};
            first = samp;
            orf   = v.or_mask[k];
         end else begin
            acc = acc + {16'd0, samp};
            orf = orf | v.or_mask[k];
         end
         if (int'(cnt) == v.d) begin
            cnt     = 16'd0;
            cnt_out = cnt_out + 32'd1;
`ifdef DECIMATOR_AVERAGE_EN
            sh     = acc >> v.shift;
            e.data = (sh > 26'd1023) ? 10'h3FF : sh[9:0];
`else
            e.data = first;
`endif
            e.or_f  = orf;
            e.count = cnt_out;
            exp_q.push_back(e);
            last_data = e.data;
            if (v.max != 0 && cnt_out == 32'(v.max)) done = 1'b1;
         end else begin
            cnt = cnt + 16'd1;
         end
         if (k == v.drop) done = 1'b1;
         tick();
      end

      // Keep feeding samples after a limit stop; none may be consumed.
      for (int k = 0; k < 3; k++) begin
         bus.adc_data_i = 10'(k * 77 + 3);
         bus.adc_or_i   = 1'b1;
         tick();
      end
      check({v.name, "_done"}, {31'd0, bus.capture_done_o}, {31'd0, v.exp_done});

      bus.capture_go_i = 1'b0;
      tick();
      tick();
      check({v.name, "_done_clear"}, {31'd0, bus.capture_done_o}, 32'd0);
      check({v.name, "_emits"}, 32'(seen_emits), 32'(v.exp_emits));
      check({v.name, "_count"}, bus.sample_count_o, 32'(v.exp_emits));
      check({v.name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      if (v.exp_emits > 0)
         check({v.name, "_data_hold"}, {22'd0, bus.data_o}, {22'd0, last_data});
      exp_q.delete();
   endtask

   vec_t vecs[8];
   vec_t hv;

   initial begin
      vecs[0] = '{"ramp_d0",      0, 0, 4,    1,  1, -1, 32'h0,  8,  4, 1'b1};
      vecs[1] = '{"ramp_d3",      3, 0, 2,    0,  1, -1, 32'h0,  12, 2, 1'b1};
      vecs[2] = '{"or_sticky",    3, 1, 2,    5,  3, -1, 32'h2,  12, 2, 1'b1};
      vecs[3] = '{"drop_partial", 1, 0, 0,    7,  2,  4, 32'h0,  10, 2, 1'b0};
      vecs[4] = '{"drop_on_emit", 1, 1, 0,    50, 9,  3, 32'h4,  10, 2, 1'b0};
      vecs[5] = '{"avg_25",       3, 2, 1,    10, 10, -1, 32'h0, 8,  1, 1'b1};
      vecs[6] = '{"saturate",     3, 0, 1, 1023, 0,  -1, 32'hF,  8,  1, 1'b1};
      vecs[7] = '{"d2_misc",      2, 1, 3,   900, 37, -1, 32'h20, 15, 3, 1'b1};

      reset             = 1'b1;
      bus.adc_data_i    = 10'd0;
      bus.adc_or_i      = 1'b0;
      bus.capture_go_i  = 1'b0;
      bus.decimate_i    = 16'd0;
      bus.avg_shift_i   = 3'd0;
      bus.max_samples_i = 32'd0;
      tick();
      tick();
      check("rst_data",  {22'd0, bus.data_o},         32'd0);
      check("rst_valid", {31'd0, bus.data_valid_o},   32'd0);
      check("rst_or",    {31'd0, bus.or_o},           32'd0);
      check("rst_done",  {31'd0, bus.capture_done_o}, 32'd0);
      check("rst_count", bus.sample_count_o,          32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_capture(vecs[i]);
      end

      // Mid-group reset with D=7: no emission, outputs cleared at once.
      bus.decimate_i    = 16'd7;
      bus.avg_shift_i   = 3'd3;
      bus.max_samples_i = 32'd1;
      bus.capture_go_i  = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         bus.adc_data_i = 10'(200 + k);
         tick();
      end
      #2 reset = 1'b1;
      #1;
      check("midrst_data",  {22'd0, bus.data_o},         32'd0);
      check("midrst_valid", {31'd0, bus.data_valid_o},   32'd0);
      check("midrst_or",    {31'd0, bus.or_o},           32'd0);
      check("midrst_count", bus.sample_count_o,          32'd0);
      bus.capture_go_i = 1'b0;
      tick();
      reset = 1'b0;
      seen_emits = 0;
      for (int k = 0; k < 10; k++) tick();
      check("midrst_no_stray_valid", 32'(seen_emits), 32'd0);
      check("midrst_idle_count", bus.sample_count_o, 32'd0);

      hv = '{"restart_d7", 7, 3, 1, 100, 1, -1, 32'h80, 12, 1, 1'b1};
      run_capture(hv);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_decimator.md
ADC_DECIMATOR -- requirements
Module: adc_decimator

Interface
REQ-001 SHALL have port clk  in  1  ADC sample clock; all logic on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port adc_data_i  in  10  registered ADC sample, one per clk.
REQ-004 SHALL have port adc_or_i  in  1  ADC out-of-range flag, aligned with adc_data_i.
REQ-005 SHALL have port capture_go_i  in  1  from trigger logic; held high for the whole capture.
REQ-006 SHALL have port decimate_i  in  16  D; group length L = D+1 input samples.
REQ-007 SHALL have port avg_shift_i  in  3  right-shift applied to group sum (averaging builds only).
REQ-008 SHALL have port max_samples_i  in  32  output-sample limit; 0 = unlimited.
REQ-009 SHALL have port data_o  out  10  decimated sample to the sample FIFO.
REQ-010 SHALL have port data_valid_o  out  1  one-cycle write strobe for data_o.
REQ-011 SHALL have port or_o  out  1  OR of adc_or_i across the emitted group.
REQ-012 SHALL have port capture_done_o  out  1  capture-stop indication back to trigger logic.
REQ-013 SHALL have port sample_count_o  out  32  output samples emitted in current/last capture.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE -> RUN on first clk with capture_go_i=1; on that edge latch decimate_i, avg_shift_i, max_samples_i, clear group counter, accumulator, sticky OR, sample_count_o.
REQ-016 The sample present on the IDLE->RUN edge SHALL NOT be consumed; the first consumed sample is the one on the next edge.
REQ-017 Config inputs SHALL be ignored while in RUN or DONE.
REQ-018 In RUN, each clk SHALL consume one sample and advance group counter 0..D, wrapping to 0 after D.
REQ-019 On the edge consuming sample with group counter = D, data_valid_o SHALL be 1 on the following cycle with data_o/or_o for that group (1-cycle latency); otherwise data_valid_o = 0.
REQ-020 D=0 SHALL emit every sample, data_valid_o continuously high in RUN.
REQ-021 sample_count_o SHALL increment on each emitted sample, 32-bit, wrapping at 2^32-1 -> 0.
REQ-022 If max_samples_i latched nonzero and an emission makes sample_count_o equal it, FSM SHALL enter DONE on that same edge and consume no further samples.
REQ-023 In DONE, capture_done_o = 1; DONE -> IDLE when capture_go_i = 0.
REQ-024 capture_go_i falling in RUN SHALL return to IDLE, discard partial group, leave capture_done_o = 0; an emission due that same edge SHALL still be output.
REQ-025 or_o SHALL be sticky within a group and cleared at group start.
REQ-026 data_o, or_o SHALL hold their last value while data_valid_o = 0.

Reset
REQ-027 reset = 1 SHALL immediately force IDLE, data_o = 0, data_valid_o = 0, or_o = 0, capture_done_o = 0, sample_count_o = 0, internal counters/accumulator = 0.
REQ-028 Reset asserted mid-RUN SHALL abort the group with no emission; after release FSM waits in IDLE for capture_go_i.

Configuration
REQ-029 Macro DECIMATOR_AVERAGE_EN SHALL select group processing.
REQ-030 With DECIMATOR_AVERAGE_EN defined: 26-bit accumulator sums all L samples; data_o = (sum >> avg_shift) saturated to 10'h3FF.
REQ-031 Without DECIMATOR_AVERAGE_EN: data_o = first sample of each group (counter = 0); avg_shift_i unused; no accumulator synthesized.

Verification
REQ-032 D=0, max=4, ramp 1,2,3,...: valid on 4 consecutive cycles with data 1,2,3,4; capture_done_o=1 next cycle; sample_count_o=4.
REQ-033 No-average build, D=3, max=2, ramp from 0: data_o 0 then 4, valid spaced 4 cycles apart; DONE after second.
REQ-034 Average build, D=3, shift=2, inputs 10,20,30,40: data_o=25; inputs all 0x3FF with shift=0: data_o=0x3FF (saturated).
REQ-035 D=3, adc_or_i=1 on 2nd sample of group 1 only: or_o=1 for group 1, 0 for group 2.
REQ-036 max=0, D=1, drop capture_go_i after 5 consumed samples: 2 emissions, capture_done_o stays 0, FSM IDLE.
REQ-037 Assert reset mid-group with D=7, then restart capture: no stray valid; sample_count_o restarts at 0, first group output correct.
